fetch_unit: RTL

- Instruction fetch stage directly upstream of the decoder.
- Holds the PC, issues word requests to instruction memory over a req/gnt + rvalid interface with at most one request outstanding, and buffers returned words in a small FIFO.
- Presents the FIFO head to the decoder with a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes all in-flight and buffered instructions.

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt + rvalid channel,
// redirect input and the valid/ready instruction handoff to the decoder.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output inst, inst_pc, inst_valid,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  inst, inst_pc, inst_valid,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request, small
// instruction FIFO towards the decoder, and redirect-driven flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state, state_next;
    logic [31:0]      pc, pc_next;
    logic [31:0]      req_pc, req_pc_next;
    logic             discard, discard_next;
    logic [CNT_W-1:0] count, count_next;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
    logic [31:0]      buf_data [DEPTH];
    logic [31:0]      buf_pc   [DEPTH];
    logic             issue, push, pop;

    assign bus.imem_req  = (state == IDLE) && (count < DEPTH_C) && !bus.redirect && rst_n;
    assign bus.imem_addr = pc;
    assign issue         = bus.imem_req && bus.imem_gnt;

    // Redirect cancels both ends of the FIFO in its cycle.
    assign push = (state == WAIT) && bus.imem_rvalid && !discard && !bus.redirect;
    assign pop  = bus.inst_valid && bus.inst_ready && !bus.redirect;

    assign bus.inst_valid = (count != '0);
    assign bus.inst       = bus.inst_valid ? buf_data[rd_ptr] : NOP_INST;
    assign bus.inst_pc    = bus.inst_valid ? buf_pc[rd_ptr]   : 32'h0;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latch).
        state_next   = state;
        pc_next      = pc;
        req_pc_next  = req_pc;
        discard_next = discard;
        count_next   = count;
        rd_ptr_next  = rd_ptr;
        wr_ptr_next  = wr_ptr;

        if (bus.redirect) begin
            pc_next     = bus.redirect_pc & ~32'h3;
            count_next  = '0;
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            if (state == WAIT) begin
                if (bus.imem_rvalid) begin
                    state_next   = IDLE;
                    discard_next = 1'b0;
                end else begin
                    // The pending response still has to be absorbed before issuing again.
                    discard_next = 1'b1;
                end
            end
        end else begin
            if (issue) begin
                pc_next     = pc + 32'd4;
                req_pc_next = pc;
                state_next  = WAIT;
            end
            if ((state == WAIT) && bus.imem_rvalid) begin
                state_next   = IDLE;
                discard_next = 1'b0;
            end
            if (push) wr_ptr_next = wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr_next = rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            req_pc  <= RESET_PC;
            discard <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            req_pc  <= req_pc_next;
            discard <= discard_next;
            count   <= count_next;
            rd_ptr  <= rd_ptr_next;
            wr_ptr  <= wr_ptr_next;
        end
    end

    // NOTE: buffer storage is deliberately not reset; count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= bus.imem_rdata;
            buf_pc[wr_ptr]   <= req_pc;
        end
    end
endmodule
